// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the fetch/data memory arbiter: FSM encodings and
// the default widths and NOP constant also used by the fetch stage.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_IBUSY = 2'd1,
        ARB_DBUSY = 2'd2
    } arb_state_e;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/mem_arbiter_req_latch.sv
// Capture register for the granted request. The address loads on every grant,
// while the write flag and write data load only on data grants.
module arb_req_latch
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              addr_en_i,
    input  logic              data_en_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              wr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              wr_o,
    output logic [DATA_W-1:0] wdata_o
);

    logic [ADDR_W-1:0] addr_q;
    logic              wr_q;
    logic [DATA_W-1:0] wdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            if (addr_en_i) addr_q <= addr_i;
            if (data_en_i) begin
                wr_q    <= wr_i;
                wdata_q <= wdata_i;
            end
        end
    end

    assign addr_o  = addr_q;
    assign wr_o    = wr_q;
    assign wdata_o = wdata_q;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one stallmem-style memory port between fetch and data. Data wins ties
// unless fetch has already lost STARVE_LIMIT consecutive arbitrations.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    output logic              i_err,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              d_err,
    output logic              mem_enable,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    input  logic              mem_ready,
    input  logic              mem_err
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] starveCnt_q, starveCnt_d;
    logic             grantI, grantD;
    logic             latchWr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            starveCnt_q <= '0;
        end else begin
            state_q     <= state_d;
            starveCnt_q <= starveCnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        starveCnt_d = starveCnt_q;
        grantI      = 1'b0;
        grantD      = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (d_req && !(i_req && starveCnt_q == CNT_MAX)) begin
                    grantD  = 1'b1;
                    state_d = ARB_DBUSY;
                end else if (i_req) begin
                    grantI  = 1'b1;
                    state_d = ARB_IBUSY;
                end
                // Fetch waiting behind a data grant ages the counter; any fetch
                // grant or an absent fetch request resets it.
                if (!i_req || grantI) begin
                    starveCnt_d = '0;
                end else if (grantD && starveCnt_q != CNT_MAX) begin
                    starveCnt_d = starveCnt_q + 1'b1;
                end
            end
            ARB_IBUSY, ARB_DBUSY: begin
                if (mem_ready) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    arb_req_latch #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_req_latch (
        .clk      (clk),
        .rst      (rst),
        .addr_en_i(grantI | grantD),
        .data_en_i(grantD),
        .addr_i   (grantD ? d_addr : i_addr),
        .wr_i     (d_wr),
        .wdata_i  (d_wdata),
        .addr_o   (mem_addr),
        .wr_o     (latchWr),
        .wdata_o  (mem_data_in)
    );

    // A completion coinciding with reset is dropped so the abandoned access
    // never reports ready.
    assign i_ready    = (state_q == ARB_IBUSY) && mem_ready && !rst;
    assign d_ready    = (state_q == ARB_DBUSY) && mem_ready && !rst;
    assign i_err      = i_ready && mem_err;
    assign d_err      = d_ready && mem_err;
    assign i_rdata    = i_ready ? mem_data_out : '0;
    assign d_rdata    = d_ready ? mem_data_out : '0;
    assign mem_enable = (state_q != ARB_IDLE);
    assign mem_wr     = (state_q == ARB_DBUSY) && latchWr;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a transaction-level model predicts every
// output each cycle, and directed scenarios pin the model with literal values.
module tb_mem_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0, d_req = 1'b0, d_wr = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_data_in;
    logic        i_ready, i_err, d_ready, d_err, mem_enable, mem_wr;
    logic [31:0] mem_data_out = '0;
    logic        mem_ready = 1'b0, mem_err = 1'b0;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready), .i_err(i_err),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready), .d_err(d_err),
        .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
        .mem_ready(mem_ready), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    // Model: who owns the port (0 none, 1 fetch, 2 data), what was captured at
    // the grant, and how many data grants fetch has lost in a row.
    int          owner = 0;
    int          lostRuns = 0;
    logic [31:0] capAddr = '0, capWdata = '0;
    logic        capWr = 1'b0;
    bit          modelValid = 1'b0;

    always @(negedge clk) begin
        if (modelValid) begin
            checkOutput("mdl_mem_enable", mem_enable, owner != 0);
            checkOutput("mdl_mem_wr", mem_wr, owner == 2 && capWr);
            checkOutput("mdl_mem_addr", mem_addr, capAddr);
            checkOutput("mdl_mem_data_in", mem_data_in, capWdata);
            checkOutput("mdl_i_ready", i_ready, owner == 1 && mem_ready && !rst);
            checkOutput("mdl_d_ready", d_ready, owner == 2 && mem_ready && !rst);
            checkOutput("mdl_i_err", i_err, owner == 1 && mem_ready && mem_err && !rst);
            checkOutput("mdl_d_err", d_err, owner == 2 && mem_ready && mem_err && !rst);
            checkOutput("mdl_i_rdata", i_rdata,
                        (owner == 1 && mem_ready && !rst) ? mem_data_out : 32'h0);
            checkOutput("mdl_d_rdata", d_rdata,
                        (owner == 2 && mem_ready && !rst) ? mem_data_out : 32'h0);
        end
        if (rst) begin
            owner = 0; lostRuns = 0;
            capAddr = '0; capWdata = '0; capWr = 1'b0;
            modelValid = 1'b1;
        end else if (owner != 0) begin
            if (mem_ready) owner = 0;
        end else if (d_req && !(i_req && lostRuns == LIMIT)) begin
            owner = 2;
            capAddr = d_addr; capWr = d_wr; capWdata = d_wdata;
            lostRuns = i_req ? ((lostRuns < LIMIT) ? lostRuns + 1 : LIMIT) : 0;
        end else if (i_req) begin
            owner = 1;
            capAddr = i_addr;
            lostRuns = 0;
        end else begin
            lostRuns = 0;
        end
    end

    int  dCount, iCycle;
    bit  iDone, dDone;

    initial begin
        applyStimulus();
        applyStimulus();
        @(negedge clk);
        checkOutput("reset_mem_enable", mem_enable, 0);
        checkOutput("reset_mem_addr", mem_addr, 0);
        checkOutput("reset_mem_data_in", mem_data_in, 0);
        applyStimulus();
        rst = 1'b0;

        // Single fetch with memory answering on the third busy cycle
        i_req = 1'b1; i_addr = 32'h100;
        @(negedge clk);
        checkOutput("fetch_idle_enable", mem_enable, 0);
        applyStimulus();
        @(negedge clk);
        checkOutput("fetch_busy_addr", mem_addr, 32'h100);
        checkOutput("fetch_busy_wr", mem_wr, 0);
        applyStimulus();
        applyStimulus();
        mem_ready = 1'b1; mem_data_out = 32'h0000_0013;
        @(negedge clk);
        checkOutput("fetch_i_ready", i_ready, 1);
        checkOutput("fetch_i_rdata", i_rdata, 32'h13);
        checkOutput("fetch_d_ready", d_ready, 0);
        applyStimulus();
        i_req = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        checkOutput("fetch_done_ready", i_ready, 0);
        applyStimulus();

        // Simultaneous requests: data first, then fetch after the turnaround
        i_req = 1'b1; d_req = 1'b1; d_wr = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF;
        applyStimulus();
        mem_ready = 1'b1;
        @(negedge clk);
        checkOutput("sim_mem_wr", mem_wr, 1);
        checkOutput("sim_mem_data_in", mem_data_in, 32'hDEAD_BEEF);
        checkOutput("sim_d_ready", d_ready, 1);
        checkOutput("sim_i_ready_low", i_ready, 0);
        applyStimulus();
        d_req = 1'b0; d_wr = 1'b0; mem_ready = 1'b0;
        applyStimulus();
        mem_ready = 1'b1;
        @(negedge clk);
        checkOutput("sim_fetch_addr", mem_addr, 32'h100);
        checkOutput("sim_fetch_wr", mem_wr, 0);
        checkOutput("sim_i_ready", i_ready, 1);
        applyStimulus();
        i_req = 1'b0; mem_ready = 1'b0;

        // Starvation: both held, memory always ready
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0; i_req = 1'b1; d_req = 1'b1; mem_ready = 1'b1;
        dCount = 0; iCycle = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (iCycle < 0 && d_ready) dCount++;
            if (iCycle < 0 && i_ready) iCycle = c;
            applyStimulus();
        end
        checkOutput("starve_data_grants", dCount, 4);
        checkOutput("starve_fetch_cycle", iCycle, 9);
        i_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
        applyStimulus();

        // Error forwarding on a data read
        d_req = 1'b1; d_addr = 32'h40;
        applyStimulus();
        mem_ready = 1'b1; mem_err = 1'b1;
        @(negedge clk);
        checkOutput("err_d_ready", d_ready, 1);
        checkOutput("err_d_err", d_err, 1);
        checkOutput("err_i_err", i_err, 0);
        applyStimulus();
        d_req = 1'b0; mem_ready = 1'b0; mem_err = 1'b0;
        applyStimulus();

        // Reset in the middle of a fetch
        i_req = 1'b1; i_addr = 32'h500;
        applyStimulus();
        rst = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        checkOutput("rstmid_i_ready", i_ready, 0);
        applyStimulus();
        rst = 1'b0; i_req = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        checkOutput("rstmid_enable", mem_enable, 0);
        checkOutput("rstmid_addr", mem_addr, 0);
        applyStimulus();

        // Address change after grant does not reach the memory port
        d_req = 1'b1; d_addr = 32'h300;
        applyStimulus();
        d_addr = 32'h304;
        @(negedge clk);
        checkOutput("hold_addr_busy", mem_addr, 32'h300);
        applyStimulus();
        mem_ready = 1'b1;
        @(negedge clk);
        checkOutput("hold_addr_done", mem_addr, 32'h300);
        checkOutput("hold_d_ready", d_ready, 1);
        applyStimulus();
        d_req = 1'b0; mem_ready = 1'b0;

        // Randomized traffic with protocol-abiding requesters
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            iDone = i_ready;
            dDone = d_ready;
            applyStimulus();
            if (!i_req || iDone) i_req = 1'($urandom_range(0, 1));
            if (!d_req || dDone) begin
                d_req = 1'($urandom_range(0, 1));
                d_wr  = 1'($urandom_range(0, 1));
            end
            i_addr       = $urandom;
            d_addr       = $urandom;
            d_wdata      = $urandom;
            mem_ready    = ($urandom_range(0, 2) == 0);
            mem_data_out = $urandom;
            mem_err      = 1'($urandom_range(0, 1));
            rst          = ($urandom_range(0, 99) == 0);
        end
        applyStimulus();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
